lsu_mem_master: RTL and testbench

- Load/store initiator that drives the word-wide data memory port (A, WD, WE, RD) on behalf of the RV32I core.
- Memory side: combinational read, write on clk rising edge, no byte enables.
- Implements LB/LH/LW/LBU/LHU with sign or zero extension, and SB/SH/SW; sub-word stores use read-modify-write.
- Sits between the execute stage (valid/ready request, one-cycle response pulse) and the data memory.

---
 rtl/lsu_mem_master.sv | 175 +++++++++++++++++
 tb/tb_lsu_mem_master.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/lsu_mem_master.sv
// RV32I load/store initiator for a word-wide, combinational-read data memory.
// Sub-word stores are done as read-modify-write; one transaction in flight at a time.
module lsu_mem_master #(
  parameter int unsigned DEPTH = 62
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [31:0] mem_A,
  output logic [31:0] mem_WD,
  output logic        mem_WE,
  input  logic [31:0] mem_RD
);

  localparam logic [29:0] DEPTH_W = 30'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_RMW_RD = 3'd2,
    S_WRITE  = 3'd3,
    S_RESP   = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] merge_q, merge_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  function automatic logic req_error(input logic we, input logic [2:0] f3,
                                     input logic [31:0] addr);
    logic illegal;
    logic misaligned;
    logic out_of_range;
    if (we) begin
      illegal = f3[2] || (f3[1:0] == 2'b11);
    end else begin
      illegal = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
    end
    misaligned   = ((f3[1:0] == 2'b01) && addr[0]) ||
                   ((f3[1:0] == 2'b10) && (addr[1:0] != 2'b00));
    out_of_range = (addr[31:2] >= DEPTH_W);
    return illegal || misaligned || out_of_range;
  endfunction

  function automatic logic [31:0] load_extract(input logic [31:0] word, input logic [2:0] f3,
                                               input logic [1:0] lane);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = word[{lane, 3'b000} +: 8];
    h = lane[1] ? word[31:16] : word[15:0];
    case (f3)
      3'b000:  r = {{24{b[7]}}, b};
      3'b001:  r = {{16{h[15]}}, h};
      3'b010:  r = word;
      3'b100:  r = {24'h000000, b};
      3'b101:  r = {16'h0000, h};
      default: r = 32'h0000_0000;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] store_merge(input logic [31:0] word, input logic [31:0] wdata,
                                              input logic [2:0] f3, input logic [1:0] lane);
    logic [31:0] r;
    r = word;
    case (f3[1:0])
      2'b00: r[{lane, 3'b000} +: 8] = wdata[7:0];
      2'b01: begin
        if (lane[1]) r[31:16] = wdata[15:0];
        else         r[15:0]  = wdata[15:0];
      end
      default: r = wdata;
    endcase
    return r;
  endfunction

  // Next-state and datapath capture
  always_comb begin
    state_d  = state_q;
    funct3_d = funct3_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    merge_d  = merge_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          funct3_d = req_funct3;
          addr_d   = req_addr;
          wdata_d  = req_wdata;
          merge_d  = req_wdata;
          rdata_d  = 32'h0000_0000;
          err_d    = req_error(req_we, req_funct3, req_addr);
          if (err_d)                         state_d = S_RESP;
          else if (!req_we)                  state_d = S_LOAD;
          else if (req_funct3[1:0] == 2'b10) state_d = S_WRITE;
          else                               state_d = S_RMW_RD;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LOAD: begin
        rdata_d = load_extract(mem_RD, funct3_q, addr_q[1:0]);
        state_d = S_RESP;
      end
      S_RMW_RD: begin
        merge_d = store_merge(mem_RD, wdata_q, funct3_q, addr_q[1:0]);
        state_d = S_WRITE;
      end
      S_WRITE: state_d = S_RESP;
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State and transaction registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      funct3_q <= 3'b000;
      addr_q   <= 32'h0000_0000;
      wdata_q  <= 32'h0000_0000;
      merge_q  <= 32'h0000_0000;
      rdata_q  <= 32'h0000_0000;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      funct3_q <= funct3_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      merge_q  <= merge_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
    end
  end

  // Memory port is driven only while a memory-touching state is active
  always_comb begin
    mem_A  = 32'h0000_0000;
    mem_WD = 32'h0000_0000;
    mem_WE = 1'b0;
    if ((state_q == S_LOAD) || (state_q == S_RMW_RD) || (state_q == S_WRITE)) begin
      mem_A = {addr_q[31:2], 2'b00};
    end else begin
      mem_A = 32'h0000_0000;
    end
    if (state_q == S_WRITE) begin
      mem_WD = merge_q;
      mem_WE = 1'b1;
    end else begin
      mem_WD = 32'h0000_0000;
      mem_WE = 1'b0;
    end
  end

  assign req_ready = (state_q == S_IDLE);
  assign rsp_valid = (state_q == S_RESP);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

endmodule

// File: tb/tb_lsu_mem_master.sv
// Directed bench for lsu_mem_master with a behavioural combinational-read memory.
module tb_lsu_mem_master;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [31:0] mem_A;
  logic [31:0] mem_WD;
  logic        mem_WE;
  logic [31:0] mem_RD;

  logic [31:0] mem [0:63];
  int          wr_cnt;
  int          n_checks;
  int          n_errors;

  lsu_mem_master #(.DEPTH(62)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_A(mem_A), .mem_WD(mem_WD), .mem_WE(mem_WE), .mem_RD(mem_RD)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mem_RD = (mem_A[31:2] < 30'd62) ? mem[mem_A[7:2]] : 32'h0000_0000;

  always @(posedge clk) begin
    if (mem_WE) begin
      mem[mem_A[7:2]] = mem_WD;
      wr_cnt = wr_cnt + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks = n_checks + 1;
    if (obs !== exp) begin
      n_errors = n_errors + 1;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // One isolated transaction; latency counted in cycles after the accept edge
  task automatic do_req(input string tag, input logic we, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input int exp_lat, input logic exp_err,
                        input logic [31:0] exp_rdata, input int exp_writes);
    int lat;
    int we_cyc;
    logic [31:0] we_addr;
    int wr0;
    lat = 0;
    we_cyc = 0;
    we_addr = 32'h0;
    @(negedge clk);
    check({tag, " ready"}, {31'h0, req_ready}, 32'h1);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
    wr0 = wr_cnt;
    @(posedge clk);
    for (int k = 1; k <= 8 && lat == 0; k++) begin
      @(negedge clk);
      req_valid = 1'b0;
      if (mem_WE && we_cyc == 0) begin
        we_cyc = k;
        we_addr = mem_A;
      end
      if (rsp_valid) begin
        lat = k;
        check({tag, " err"}, {31'h0, rsp_err}, {31'h0, exp_err});
        check({tag, " rdata"}, rsp_rdata, exp_rdata);
        check({tag, " ready_in_resp"}, {31'h0, req_ready}, 32'h0);
      end
    end
    check({tag, " latency"}, 32'(lat), 32'(exp_lat));
    check({tag, " writes"}, 32'(wr_cnt - wr0), 32'(exp_writes));
    if (exp_writes != 0) begin
      check({tag, " we_cycle"}, 32'(we_cyc), 32'(exp_lat - 1));
      check({tag, " we_addr"}, we_addr, {addr[31:2], 2'b00});
    end
    @(negedge clk);
    check({tag, " rsp_pulse"}, {31'h0, rsp_valid}, 32'h0);
  endtask

  logic        vec_we   [0:3];
  logic [2:0]  vec_f3   [0:3];
  logic [31:0] vec_addr [0:3];
  logic [31:0] vec_wd   [0:3];
  logic [31:0] vec_exp  [0:3];

  initial begin
    int acc;
    int nrsp;
    logic will_acc;
    n_checks = 0; n_errors = 0; wr_cnt = 0;
    for (int i = 0; i < 64; i++) mem[i] = 32'h0000_0000;
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b000;
    req_addr = 32'h0; req_wdata = 32'h0;
    #12;
    check("rst ready", {31'h0, req_ready}, 32'h1);
    check("rst rsp_valid", {31'h0, rsp_valid}, 32'h0);
    check("rst rdata", rsp_rdata, 32'h0);
    check("rst err", {31'h0, rsp_err}, 32'h0);
    check("rst mem_A", mem_A, 32'h0);
    check("rst mem_WD", mem_WD, 32'h0);
    check("rst mem_WE", {31'h0, mem_WE}, 32'h0);
    @(negedge clk); rst_n = 1'b1;

    mem[3] = 32'h8899AABB;
    mem[61] = 32'hCAFEF00D;
    do_req("lb",  1'b0, 3'b000, 32'h0F, 32'h0, 2, 1'b0, 32'hFFFFFF88, 0);
    do_req("lbu", 1'b0, 3'b100, 32'h0E, 32'h0, 2, 1'b0, 32'h00000099, 0);
    do_req("lh",  1'b0, 3'b001, 32'h0C, 32'h0, 2, 1'b0, 32'hFFFFAABB, 0);
    do_req("lhu", 1'b0, 3'b101, 32'h0E, 32'h0, 2, 1'b0, 32'h00008899, 0);
    do_req("lb0", 1'b0, 3'b000, 32'h0C, 32'h0, 2, 1'b0, 32'hFFFFFFBB, 0);
    do_req("lw_last", 1'b0, 3'b010, 32'hF4, 32'h0, 2, 1'b0, 32'hCAFEF00D, 0);

    do_req("sw",  1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 2, 1'b0, 32'h0, 1);
    do_req("lw",  1'b0, 3'b010, 32'h10, 32'h0, 2, 1'b0, 32'hDEADBEEF, 0);

    mem[4] = 32'h11223344;
    do_req("sb",  1'b1, 3'b000, 32'h11, 32'h000000AB, 3, 1'b0, 32'h0, 1);
    check("sb word", mem[4], 32'h1122AB44);
    do_req("sh",  1'b1, 3'b001, 32'h12, 32'h0000CDEF, 3, 1'b0, 32'h0, 1);
    check("sh word", mem[4], 32'hCDEFAB44);

    do_req("e_lw_mis", 1'b0, 3'b010, 32'h06, 32'h0, 1, 1'b1, 32'h0, 0);
    do_req("e_sh_mis", 1'b1, 3'b001, 32'h03, 32'h1234, 1, 1'b1, 32'h0, 0);
    do_req("e_oor",    1'b0, 3'b010, 32'hF8, 32'h0, 1, 1'b1, 32'h0, 0);
    do_req("e_f3_ld",  1'b0, 3'b011, 32'h00, 32'h0, 1, 1'b1, 32'h0, 0);
    do_req("e_f3_st",  1'b1, 3'b100, 32'h00, 32'h0, 1, 1'b1, 32'h0, 0);
    check("err word4 intact", mem[4], 32'hCDEFAB44);

    // Reset while an SB sits in WRITE: the write must never land
    mem[5] = 32'h55667788;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b000; req_addr = 32'h14; req_wdata = 32'hAA;
    @(posedge clk);
    @(negedge clk); req_valid = 1'b0;
    @(negedge clk);
    check("rstw in_write", {31'h0, mem_WE}, 32'h1);
    rst_n = 1'b0;
    #1;
    check("rstw mem_WE", {31'h0, mem_WE}, 32'h0);
    check("rstw mem_A", mem_A, 32'h0);
    check("rstw mem_WD", mem_WD, 32'h0);
    check("rstw rsp_valid", {31'h0, rsp_valid}, 32'h0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    check("rstw word", mem[5], 32'h55667788);
    check("rstw ready", {31'h0, req_ready}, 32'h1);
    check("rstw no_rsp", {31'h0, rsp_valid}, 32'h0);

    // Back-to-back with req_valid held high
    vec_we[0] = 1'b1; vec_f3[0] = 3'b010; vec_addr[0] = 32'h20; vec_wd[0] = 32'h12345678; vec_exp[0] = 32'h0;
    vec_we[1] = 1'b0; vec_f3[1] = 3'b010; vec_addr[1] = 32'h20; vec_wd[1] = 32'h0;        vec_exp[1] = 32'h12345678;
    vec_we[2] = 1'b1; vec_f3[2] = 3'b001; vec_addr[2] = 32'h22; vec_wd[2] = 32'h0000BEEF; vec_exp[2] = 32'h0;
    vec_we[3] = 1'b0; vec_f3[3] = 3'b001; vec_addr[3] = 32'h22; vec_wd[3] = 32'h0;        vec_exp[3] = 32'hFFFFBEEF;
    acc = 0; nrsp = 0; will_acc = 1'b0;
    @(negedge clk);
    req_valid = 1'b1; req_we = vec_we[0]; req_funct3 = vec_f3[0];
    req_addr = vec_addr[0]; req_wdata = vec_wd[0];
    for (int c = 0; c < 80 && nrsp < 4; c++) begin
      will_acc = req_valid && req_ready;
      @(negedge clk);
      if (rsp_valid) begin
        check("b2b rdata", rsp_rdata, vec_exp[nrsp]);
        check("b2b err", {31'h0, rsp_err}, 32'h0);
        check("b2b ready_low", {31'h0, req_ready}, 32'h0);
        nrsp = nrsp + 1;
      end
      if (will_acc) begin
        acc = acc + 1;
        if (acc < 4) begin
          req_we = vec_we[acc]; req_funct3 = vec_f3[acc];
          req_addr = vec_addr[acc]; req_wdata = vec_wd[acc];
        end else begin
          req_valid = 1'b0;
        end
      end
    end
    req_valid = 1'b0;
    check("b2b accepts", 32'(acc), 32'd4);
    check("b2b responses", 32'(nrsp), 32'd4);
    check("b2b word", mem[8], 32'hBEEF5678);
    repeat (3) @(negedge clk);
    check("b2b quiet", {31'h0, rsp_valid}, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
